// File: rtl/lap_timer.sv
// lap_timer: stopwatch with a prescaled live-time counter and a small lap store.
//
// Build option: define LAP_TIMER_SPLIT_EN to show each stored lap as a split
// (difference from the previous lap, modulo WRAP_TICKS). The default build
// shows cumulative lap times.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-low reset
//   run        1 = counting, 0 = paused
//   lap_n      raw active-low lap button, asynchronous to clk
//   sel        0 = live time, k in 1..LAP_DEPTH = lap k
//   time_out   registered display value (1-cycle latency)
//   lap_count  number of laps stored
//   laps_full  high when lap_count == LAP_DEPTH
//   tick       one-cycle pulse on every live-time increment
module lap_timer #(
  parameter int CLK_PER_TICK = 500000,
  parameter int TIME_W       = 19,
  parameter int WRAP_TICKS   = 360000,
  parameter int LAP_DEPTH    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              lap_n,
  input  logic [3:0]        sel,
  output logic [TIME_W-1:0] time_out,
  output logic [3:0]        lap_count,
  output logic              laps_full,
  output logic              tick
);

  localparam int                PRE_W    = $clog2(CLK_PER_TICK);
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(CLK_PER_TICK - 1);
  localparam logic [TIME_W-1:0] LIVE_MAX = TIME_W'(WRAP_TICKS - 1);
  localparam logic [3:0]        DEPTH    = 4'(LAP_DEPTH);

  logic [PRE_W-1:0]  presc;
  logic [TIME_W-1:0] live;
  logic [TIME_W-1:0] slots     [LAP_DEPTH];
  logic [TIME_W-1:0] lap_view  [LAP_DEPTH];
  logic [TIME_W-1:0] disp;
  logic              sync1, sync2, lap_prev;
  logic              tick_now, capture;

  assign tick_now  = run && (presc == PRE_MAX);
  // Release edge of the synchronised button; flops idle high so a button held
  // through reset only counts once it is let go.
  assign capture   = sync2 && !lap_prev;
  assign laps_full = (lap_count == DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      live  <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= tick_now;
      if (tick_now) begin
        presc <= '0;
        live  <= (live == LIVE_MAX) ? '0 : live + 1'b1;
      end else if (run) begin
        presc <= presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      lap_prev <= 1'b1;
    end else begin
      sync1    <= lap_n;
      sync2    <= sync1;
      lap_prev <= sync2;
    end
  end

  // Capture takes the pre-increment live value when it lands on a tick cycle,
  // because live is read before its own update at the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_count <= '0;
      for (int k = 0; k < LAP_DEPTH; k++) slots[k] <= '0;
    end else if (capture && !laps_full) begin
      lap_count <= lap_count + 1'b1;
      for (int k = 0; k < LAP_DEPTH; k++) begin
        if (lap_count == 4'(k)) slots[k] <= live;
      end
    end
  end

`ifdef LAP_TIMER_SPLIT_EN
  // Both operands are below WRAP_TICKS, so the true result is below
  // 2^TIME_W and plain TIME_W-bit wrap-around arithmetic is exact.
  function automatic logic [TIME_W-1:0] mod_diff(input logic [TIME_W-1:0] a,
                                                 input logic [TIME_W-1:0] b);
    if (a >= b) return a - b;
    else        return a - b + TIME_W'(WRAP_TICKS);
  endfunction

  always_comb begin
    lap_view[0] = slots[0];
    for (int k = 1; k < LAP_DEPTH; k++) lap_view[k] = mod_diff(slots[k], slots[k-1]);
  end
`else
  always_comb begin
    for (int k = 0; k < LAP_DEPTH; k++) lap_view[k] = slots[k];
  end
`endif

  always_comb begin
    disp = '0;
    if (sel == 4'd0) begin
      disp = live;
    end else begin
      for (int k = 1; k <= LAP_DEPTH; k++) begin
        if (sel == 4'(k) && lap_count >= 4'(k)) disp = lap_view[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) time_out <= '0;
    else      time_out <= disp;
  end

endmodule

// File: tb/tb_lap_timer.sv
// Self-checking bench for lap_timer: directed scenarios plus random run/sel/
// button activity, compared every cycle against an arithmetic reference model.
module tb_lap_timer;

  localparam int P = 4;
  localparam int W = 20;
  localparam int D = 4;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic          lap_n = 1'b1;
  logic [3:0]    sel = 4'd0;
  logic [TW-1:0] time_out;
  logic [3:0]    lap_count;
  logic          laps_full;
  logic          tick;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;

  lap_timer #(.CLK_PER_TICK(P), .TIME_W(TW), .WRAP_TICKS(W), .LAP_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .run(run), .lap_n(lap_n), .sel(sel),
    .time_out(time_out), .lap_count(lap_count), .laps_full(laps_full), .tick(tick)
  );

  always #5 clk = ~clk;

  // Reference model: live time is derived from the number of running clock
  // edges; laps are a queue of captured times.
  int n;
  int laps[$];
  bit h1, h2, h3;  // lap_n samples from the previous three edges
  int exp_time;
  bit exp_tick;

  function automatic int view(int s, int live_t);
    int d;
    if (s == 0) return live_t;
    if (s >= 1 && s <= laps.size()) begin
`ifdef LAP_TIMER_SPLIT_EN
      if (s == 1) return laps[0];
      d = laps[s-1] - laps[s-2];
      if (d < 0) d += W;
      return d;
`else
      d = laps[s-1];
      return d;
`endif
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    int live_t;
    if (!rst) begin
      n = 0; laps.delete(); h1 = 1; h2 = 1; h3 = 1;
      exp_time = 0; exp_tick = 0;
    end else begin
      live_t = (n / P) % W;
      exp_time = view(int'(sel), live_t);
      // release sampled two edges ago becomes a capture at this edge
      if (h2 && !h3 && laps.size() < D) laps.push_back(live_t);
      h3 = h2; h2 = h1; h1 = lap_n;
      exp_tick = 0;
      if (run) begin
        n++;
        exp_tick = (n % P == 0);
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (tick) tick_cnt++;
      chk("time_out", int'(time_out), exp_time);
      chk("tick", int'(tick), int'(exp_tick));
      chk("lap_count", int'(lap_count), laps.size());
      chk("laps_full", int'(laps_full), int'(laps.size() == D));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  task automatic press();
    lap_n = 1'b0;
    step(2);
    lap_n = 1'b1;
    step(4);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("reset_time", int'(time_out), 0);
    chk("reset_count", int'(lap_count), 0);

    // 40 running cycles give 10 ticks and live time 10
    tick_cnt = 0;
    run = 1'b1;
    step(40);
    run = 1'b0;
    step(1);
    chk("ticks_40", tick_cnt, 10);
    chk("live_10", int'(time_out), 10);

    // wrap: 84 running cycles = 21 ticks -> 1 modulo 20
    do_reset();
    run = 1'b1;
    step(84);
    run = 1'b0;
    step(1);
    chk("live_wrap", int'(time_out), 1);

    // laps captured while paused at live 3, 7, 12
    do_reset();
    run = 1'b1; step(12); run = 1'b0; press();
    run = 1'b1; step(16); run = 1'b0; press();
    run = 1'b1; step(20); run = 1'b0; press();
    for (int s = 1; s <= 4; s++) begin
      int e;
`ifdef LAP_TIMER_SPLIT_EN
      e = (s == 1) ? 3 : (s == 2) ? 4 : (s == 3) ? 5 : 0;
`else
      e = (s == 1) ? 3 : (s == 2) ? 7 : (s == 3) ? 12 : 0;
`endif
      sel = 4'(s);
      step(1);
      chk("lap_sel", int'(time_out), e);
    end

    // full store: further presses change nothing
    press(); press();
    chk("full_count", int'(lap_count), 4);
    chk("full_flag", int'(laps_full), 1);
    sel = 4'd3;
    step(1);
    chk("full_keep", int'(time_out), view(3, 0));
    sel = 4'd7;
    step(1);
    chk("sel_oob", int'(time_out), 0);

    // release landing on the 9 -> 10 tick stores 9
    sel = 4'd0;
    do_reset();
    run = 1'b1;
    step(30);
    lap_n = 1'b0;
    step(7);
    lap_n = 1'b1;
    step(5);
    run = 1'b0;
    sel = 4'd1;
    step(1);
    chk("tick_capture", int'(time_out), 9);

    // button held through reset: no capture until release, then exactly one
    sel = 4'd0;
    lap_n = 1'b0;
    do_reset();
    step(5);
    chk("held_reset", int'(lap_count), 0);
    lap_n = 1'b1;
    step(5);
    chk("held_release", int'(lap_count), 1);

    // random activity
    for (int i = 0; i < 3000; i++) begin
      run = ($urandom_range(0, 3) != 0);
      sel = 4'($urandom_range(0, 6));
      if ($urandom_range(0, 5) == 0) lap_n = ~lap_n;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
